// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and constants for the March C- memory BIST.
//   - state_e  : controller FSM states (IDLE/RUN/DONE)
//   - elem_e   : March C- elements E0..E5
//   - ELEM_*   : per-element direction, op pattern, read-expect bit, write bit
//   - BG_*     : data backgrounds, bg_word() picks one per address/polarity
// Optional feature: MEM_BIST_CHECKERBOARD_EN selects 5555/AAAA checkerboard
// backgrounds instead of solid 0000/FFFF.
package mem_bist_pkg;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

   typedef enum logic [2:0] {
      E0 = 3'd0, E1 = 3'd1, E2 = 3'd2, E3 = 3'd3, E4 = 3'd4, E5 = 3'd5
   } elem_e;

   localparam int unsigned OP_COUNT = 160;

   // One bit per element, indexed by elem_e (bits 7:6 unused)
   localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // E3,E4 run 15->0
   localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;  // E1..E5 read
   localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;  // E0..E4 write
   localparam logic [7:0] ELEM_RD_BIT = 8'b0001_0100;  // E2,E4 expect "1"
   localparam logic [7:0] ELEM_WR_BIT = 8'b0000_1010;  // E1,E3 write "1"

`ifdef MEM_BIST_CHECKERBOARD_EN
   localparam logic [15:0] BG_EVEN = 16'h5555;
   localparam logic [15:0] BG_ODD  = 16'hAAAA;
`else
   localparam logic [15:0] BG_EVEN = 16'h0000;
   localparam logic [15:0] BG_ODD  = 16'h0000;
`endif

   // "0" background for the address parity, inverted for "1"
   function automatic logic [15:0] bg_word(input logic odd_addr, input logic ones);
      bg_word = (odd_addr ? BG_ODD : BG_EVEN) ^ {16{ones}};
   endfunction

endpackage

// File: rtl/mem_bist_drv.sv
// mem_bist_drv: falling-edge retiming stage for the memory command port so
// addr/din/cs/we stay stable across the whole clk high phase.
// Ports: clk_i, rst_n_i (sync active-low, sampled on falling edge),
//        cs_i/we_i/addr_i/din_i (command from FSM), mem_*_o (to memory).
module mem_bist_drv #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          cs_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] din_i,
   output logic          mem_cs_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_din_o
);

   // Launch the command on the falling edge
   always_ff @(negedge clk_i) begin
      if (!rst_n_i) begin
         mem_cs_o   <= 1'b0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_din_o  <= '0;
      end else begin
         mem_cs_o   <= cs_i;
         mem_we_o   <= we_i;
         mem_addr_o <= addr_i;
         mem_din_o  <= din_i;
      end
   end

endmodule

// File: rtl/mem_march_bist.sv
// mem_march_bist: March C- BIST initiator for a 16x16 flip-flop memory.
// Ports: clk_i, rst_n_i (sync active-low), start_i; status busy_o, done_o,
//        pass_o, fail_addr_o/fail_exp_o/fail_got_o (first mismatch);
//        memory port mem_addr_o/mem_din_o/mem_cs_o/mem_we_o, mem_dout_i.
// Optional feature: MEM_BIST_CHECKERBOARD_EN (checkerboard backgrounds).
module mem_march_bist
   import mem_bist_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DW    = 16,
   parameter int AW    = 12
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          pass_o,
   output logic [AW-1:0] fail_addr_o,
   output logic [DW-1:0] fail_exp_o,
   output logic [DW-1:0] fail_got_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_din_o,
   output logic          mem_cs_o,
   output logic          mem_we_o,
   input  logic [DW-1:0] mem_dout_i
);

   localparam int AWI = $clog2(DEPTH);

   state_e           state_q;
   elem_e            elem_q;
   logic [AWI-1:0]   addr_q;
   logic             phase_q;     // 0 = read, 1 = write within a (r,w) pair
   logic             ok_q;
   logic [AW-1:0]    fail_addr_q;
   logic [DW-1:0]    fail_exp_q, fail_got_q;
   logic             busy_q, done_q, pass_q;

   logic             run_s, has_rd_s, has_wr_s, op_wr_s, op_rd_s;
   logic             step_s, wrap_s, last_s, mismatch_s;
   logic [DW-1:0]    exp_s;
   logic [AW-1:0]    addr_ext_s;
   elem_e            elem_nxt_s;
   logic             cmd_cs_d, cmd_we_d;
   logic [AW-1:0]    cmd_addr_d;
   logic [DW-1:0]    cmd_din_d;

   // Decode the current op and its command from the march position
   always_comb begin
      run_s      = (state_q == ST_RUN);
      has_rd_s   = ELEM_HAS_RD[elem_q];
      has_wr_s   = ELEM_HAS_WR[elem_q];
      op_wr_s    = run_s & has_wr_s & (phase_q | ~has_rd_s);
      op_rd_s    = run_s & ~op_wr_s;
      exp_s      = bg_word(addr_q[0], ELEM_RD_BIT[elem_q]);
      mismatch_s = op_rd_s & (mem_dout_i != exp_s);
      // Address moves after the last op of the element at this address
      step_s     = ~(has_rd_s & has_wr_s & ~phase_q);
      wrap_s     = ELEM_DOWN[elem_q] ? (addr_q == AWI'(0)) : (addr_q == AWI'(DEPTH - 1));
      last_s     = (elem_q == E5) & step_s & wrap_s;
      elem_nxt_s = elem_e'(elem_q + 3'd1);
      addr_ext_s = {{(AW - AWI){1'b0}}, addr_q};
      cmd_cs_d   = run_s;
      cmd_we_d   = op_wr_s;
      cmd_addr_d = run_s ? addr_ext_s : '0;
      cmd_din_d  = op_wr_s ? bg_word(addr_q[0], ELEM_WR_BIT[elem_q]) : '0;
   end

   // Controller FSM: sequencing, compare and first-failure capture
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         elem_q      <= E0;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         ok_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_exp_q  <= '0;
         fail_got_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
                  ok_q        <= 1'b1;
                  pass_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_exp_q  <= '0;
                  fail_got_q  <= '0;
                  elem_q      <= E0;
                  addr_q      <= '0;
                  phase_q     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (mismatch_s && ok_q) begin
                  ok_q        <= 1'b0;
                  fail_addr_q <= addr_ext_s;
                  fail_exp_q  <= exp_s;
                  fail_got_q  <= mem_dout_i;
               end
               if (last_s) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= ok_q & ~mismatch_s;   // include the final read
               end else if (!step_s) begin
                  phase_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
                  if (wrap_s) begin
                     // Next element starts at its own direction's first address
                     elem_q <= elem_nxt_s;
                     addr_q <= ELEM_DOWN[elem_nxt_s] ? AWI'(DEPTH - 1) : AWI'(0);
                  end else if (ELEM_DOWN[elem_q]) begin
                     addr_q <= addr_q - AWI'(1);
                  end else begin
                     addr_q <= addr_q + AWI'(1);
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign pass_o      = pass_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_exp_o  = fail_exp_q;
   assign fail_got_o  = fail_got_q;

   mem_bist_drv #(.AW(AW), .DW(DW)) u_drv (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .cs_i       (cmd_cs_d),
      .we_i       (cmd_we_d),
      .addr_i     (cmd_addr_d),
      .din_i      (cmd_din_d),
      .mem_cs_o   (mem_cs_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_din_o  (mem_din_o)
   );

endmodule

// File: tb/tb_mem_march_bist.sv
// tb_mem_march_bist: directed bench for mem_march_bist with a behavioural
// 16x16 memory that can inject a stuck-at-1 or a coupling fault.
module tb_mem_march_bist;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        busy, done, pass;
   logic [11:0] fail_addr, mem_addr;
   logic [15:0] fail_exp, fail_got, mem_din, mem_dout;
   logic        mem_cs, mem_we;

   int n_cmp = 0;
   int n_bad = 0;
   int fault_mode = 0;   // 0 good, 1 stuck-at-1 w5.b3, 2 write w9 flips w10.b0
   logic [15:0] mem [16];

   always #5 clk = ~clk;

   mem_march_bist dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
      .busy_o(busy), .done_o(done), .pass_o(pass),
      .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_got_o(fail_got),
      .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_cs_o(mem_cs),
      .mem_we_o(mem_we), .mem_dout_i(mem_dout)
   );

   // Behavioural memory: write at rising edge, combinational read
   always @(posedge clk) begin
      if (mem_cs && mem_we) begin
         mem[mem_addr[3:0]] <= mem_din;
         if (fault_mode == 2 && mem_addr[3:0] == 4'd9)
            mem[10] <= mem[10] ^ 16'h0001;
      end
   end

   always_comb begin
      mem_dout = mem[mem_addr[3:0]];
      if (fault_mode == 1 && mem_addr[3:0] == 4'd5) mem_dout = mem_dout | 16'h0008;
   end

   function automatic logic [15:0] bg(input int a, input logic ones);
`ifdef MEM_BIST_CHECKERBOARD_EN
      bg = ((a % 2) == 1 ? 16'hAAAA : 16'h5555) ^ {16{ones}};
`else
      bg = ones ? 16'hFFFF : 16'h0000;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Ticks until done (bounded); counts ticks and busy cycles
   task automatic wait_done(output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (!done && n < 400) begin
         if (busy) nbusy++;
         tick();
         n++;
      end
   endtask

   int n, nb, dseen;

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      tick(); tick();
      @(negedge clk); #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_fail", {fail_addr, fail_exp, fail_got}, 0);
      check("rst_mem", {mem_cs, mem_we, mem_addr, mem_din}, 0);
      rst_n = 1'b1;
      tick();

      // Good memory: E0 launch order, 160-cycle run, pass
      launch();
      check("run_busy_p0", busy, 1);
      @(negedge clk); #1;
      check("e0_op0", {mem_cs, mem_we, mem_addr, mem_din}, {2'b11, 12'd0, bg(0, 1'b0)});
      tick();
      @(negedge clk); #1;
      check("e0_op1", {mem_cs, mem_we, mem_addr, mem_din}, {2'b11, 12'd1, bg(1, 1'b0)});
      wait_done(n, nb);
      check("good_len", n, 159);
      check("good_busy_at_done", busy, 0);
      check("good_pass", pass, 1);
      check("good_fail", {fail_addr, fail_exp, fail_got}, 0);
      @(negedge clk); #1;
      check("done_mem_idle", {mem_cs, mem_we, mem_addr, mem_din}, 0);
      tick();
      check("done_pulse_end", done, 0);

      // Stuck-at-1 on bit 3 of word 5
      fault_mode = 1;
      launch();
      wait_done(n, nb);
      check("sa_len", n, 160);
      check("sa_busy_cycles", nb, 160);
      check("sa_pass", pass, 0);
      check("sa_addr", fail_addr, 5);
`ifdef MEM_BIST_CHECKERBOARD_EN
      check("sa_exp", fail_exp, 16'h5555);
      check("sa_got", fail_got, 16'h555D);
`else
      check("sa_exp", fail_exp, 16'h0000);
      check("sa_got", fail_got, 16'h0008);
`endif
      tick();

      // Coupling fault: first capture (E1 read of word 10) must survive
      fault_mode = 2;
      launch();
      wait_done(n, nb);
      check("cf_len", n, 160);
      check("cf_pass", pass, 0);
      check("cf_addr", fail_addr, 10);
      check("cf_exp", fail_exp, bg(10, 1'b0));
      check("cf_got", fail_got, bg(10, 1'b0) ^ 16'h0001);
      tick();

      // Reset at P0+50 aborts; restart passes
      fault_mode = 0;
      launch();
      repeat (49) tick();
      rst_n = 1'b0;
      tick();
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_pass", pass, 0);
      @(negedge clk); #1;
      check("abort_mem", {mem_cs, mem_we}, 0);
      rst_n = 1'b1;
      dseen = 0;
      repeat (5) begin
         tick();
         if (done) dseen++;
      end
      check("abort_no_done", dseen, 0);
      launch();
      wait_done(n, nb);
      check("restart_len", n, 160);
      check("restart_pass", pass, 1);
      tick();

      // start held high: single run, next run only after DONE->IDLE
      start = 1'b1;
      tick();
      wait_done(n, nb);
      check("hold_len", n, 160);
      check("hold_pass", pass, 1);
      tick();
      check("hold_idle_busy", busy, 0);
      check("hold_idle_done", done, 0);
      tick();
      check("hold_rerun_busy", busy, 1);
      start = 1'b0;
      wait_done(n, nb);
      check("hold_rerun_len", n, 160);
      check("hold_rerun_pass", pass, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
